// File: rtl/gf180mcu_fd_sc_mcu9t5v0__bufq.sv
// Elastic valid/ready FIFO buffer: DEPTH x WIDTH circular store with occupancy count.
// Define GF180MCU_FD_SC_MCU9T5V0_BUFQ_BYPASS_EN for zero-latency fall-through when empty.
module gf180mcu_fd_sc_mcu9t5v0__bufq #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 2,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] I,
    input  logic             IV,
    output logic             IR,
    output logic [WIDTH-1:0] Z,
    output logic             ZV,
    input  logic             ZR,
    output logic [CW-1:0]    COUNT,
    inout  wire              VDD,
    inout  wire              VSS
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wp;
    logic [PW-1:0]    rp;
    logic [CW-1:0]    count;
    logic             rst_q;
    logic             empty;
    logic             full;
    logic             push;
    logic             pop;
    logic             push_mem;
    logic             pop_mem;

    // Supply pins exist only for the library pinout.
    wire unused_supply = &{1'b0, VDD, VSS};

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));
    assign IR    = !rst_q && !full;
    assign push  = IV && IR;

`ifdef GF180MCU_FD_SC_MCU9T5V0_BUFQ_BYPASS_EN
    // When empty, an offered word is presented directly; push is already gated off in reset.
    assign ZV = !empty || push;
    assign Z  = !empty ? mem[rp] : (push ? I : '0);
`else
    assign ZV = !empty;
    assign Z  = ZV ? mem[rp] : '0;
`endif

    assign pop      = ZV && ZR;
    assign pop_mem  = pop && !empty;
    // A word that falls straight through an empty queue is never stored.
    assign push_mem = push && !(empty && pop);
    assign COUNT    = count;

    always_ff @(posedge CLK) begin
        rst_q <= RST;
        if (RST) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (push_mem) begin
                wp <= next_ptr(wp);
            end
            if (pop_mem) begin
                rp <= next_ptr(rp);
            end
            case ({push_mem, pop_mem})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST && push_mem) begin
            mem[wp] <= I;
        end
    end

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__bufq.sv
// Bench for the elastic buffer queue: two instances (DEPTH 4 and 3) checked against a queue model.
module tb_gf180mcu_fd_sc_mcu9t5v0__bufq;
    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] din [2];
    logic       iv  [2];
    logic       zr  [2];
    logic       ir  [2];
    logic       zv  [2];
    logic [7:0] z   [2];
    logic [2:0] cnt0;
    logic [1:0] cnt1;
    wire        vdd;
    wire        vss;
    assign vdd = 1'b1;
    assign vss = 1'b0;

    logic [7:0] mq [2][$];
    bit         mr [2] = '{1'b1, 1'b1};
    bit         started = 1'b0;
    int         n_checks = 0;
    int         n_fail = 0;

    always #5 clk = ~clk;

    gf180mcu_fd_sc_mcu9t5v0__bufq #(.WIDTH(8), .DEPTH(4)) dut0 (
        .CLK(clk), .RST(rst), .I(din[0]), .IV(iv[0]), .IR(ir[0]),
        .Z(z[0]), .ZV(zv[0]), .ZR(zr[0]), .COUNT(cnt0), .VDD(vdd), .VSS(vss)
    );

    gf180mcu_fd_sc_mcu9t5v0__bufq #(.WIDTH(8), .DEPTH(3)) dut1 (
        .CLK(clk), .RST(rst), .I(din[1]), .IV(iv[1]), .IR(ir[1]),
        .Z(z[1]), .ZV(zv[1]), .ZR(zr[1]), .COUNT(cnt1), .VDD(vdd), .VSS(vss)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int dep(input int k);
        return (k == 0) ? 4 : 3;
    endfunction

    // What the outputs must be, from the queue contents and the current inputs.
    function automatic void expect_out(input int k, output logic e_ir, output logic e_zv,
                                       output logic [7:0] e_z);
        e_ir = !mr[k] && (mq[k].size() != dep(k));
`ifdef GF180MCU_FD_SC_MCU9T5V0_BUFQ_BYPASS_EN
        e_zv = (mq[k].size() != 0) || (iv[k] && e_ir);
        e_z  = (mq[k].size() != 0) ? mq[k][0] : (e_zv ? din[k] : 8'h00);
`else
        e_zv = (mq[k].size() != 0);
        e_z  = e_zv ? mq[k][0] : 8'h00;
`endif
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            logic       e_ir;
            logic       e_zv;
            logic [7:0] unused_ez;
            logic       m_push;
            logic       m_pop;
            expect_out(k, e_ir, e_zv, unused_ez);
            m_push = iv[k] && e_ir;
            m_pop  = e_zv && zr[k];
            if (rst) begin
                mq[k].delete();
            end else if (!(m_pop && mq[k].size() == 0)) begin
                if (m_pop) void'(mq[k].pop_front());
                if (m_push) mq[k].push_back(din[k]);
            end
            mr[k] = rst;
        end
        started = 1'b1;
    end

    always @(negedge clk) begin
        if (started) begin
            for (int k = 0; k < 2; k++) begin
                logic       e_ir;
                logic       e_zv;
                logic [7:0] e_z;
                expect_out(k, e_ir, e_zv, e_z);
                chk($sformatf("ir%0d", k), 32'(ir[k]), 32'(e_ir));
                chk($sformatf("zv%0d", k), 32'(zv[k]), 32'(e_zv));
                chk($sformatf("z%0d", k), 32'(z[k]), 32'(e_z));
                chk($sformatf("count%0d", k), (k == 0) ? 32'(cnt0) : 32'(cnt1),
                    32'(mq[k].size()));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rcv [$];
        int         sent;
        bit         acc;

        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            din[k] = 8'h00;
            iv[k]  = 1'b0;
            zr[k]  = 1'b0;
        end
        din[0] = 8'hA5;
        iv[0]  = 1'b1;

        // Reset held for three edges with a push offered.
        for (int r = 0; r < 3; r++) begin
            step();
            if (r == 2) begin
                rst   = 1'b0;
                iv[0] = 1'b0;
            end
            @(negedge clk);
            chk("rst_count", 32'(cnt0), 32'd0);
            chk("rst_zv", 32'(zv[0]), 32'd0);
            chk("rst_z", 32'(z[0]), 32'd0);
            chk("rst_ir", 32'(ir[0]), 32'd0);
        end
        step();
        @(negedge clk);
        chk("ir_after_rst", 32'(ir[0]), 32'd1);

        // Fill to DEPTH, then a refused fifth push, then drain.
        step();
        for (int v = 1; v <= 4; v++) begin
            din[0] = 8'(v);
            iv[0]  = 1'b1;
            step();
        end
        din[0] = 8'h05;
        @(negedge clk);
        chk("full_count", 32'(cnt0), 32'd4);
        chk("full_ir", 32'(ir[0]), 32'd0);
        chk("model_full_size", 32'(mq[0].size()), 32'd4);
        chk("model_full_head", 32'(mq[0][0]), 32'h01);
        step();
        iv[0] = 1'b0;
        zr[0] = 1'b1;
        for (int j = 1; j <= 4; j++) begin
            @(negedge clk);
            chk("drain_z", 32'(z[0]), 32'(j));
            if (j == 1) chk("refused_count", 32'(cnt0), 32'd4);
            step();
        end
        @(negedge clk);
        chk("drained_count", 32'(cnt0), 32'd0);
        chk("drained_zv", 32'(zv[0]), 32'd0);
        chk("drained_z", 32'(z[0]), 32'd0);

        // Simultaneous push/pop at COUNT=2, then push refused at COUNT=4.
        step();
        zr[0] = 1'b0;
        iv[0] = 1'b1;
        din[0] = 8'h10;
        step();
        din[0] = 8'h11;
        step();
        zr[0] = 1'b1;
        for (int c = 0; c < 5; c++) begin
            din[0] = 8'h12 + 8'(c);
            @(negedge clk);
            chk("sim_z", 32'(z[0]), 32'h10 + 32'(c));
            chk("sim_count", 32'(cnt0), 32'd2);
            step();
        end
        zr[0] = 1'b0;
        din[0] = 8'h17;
        step();
        din[0] = 8'h18;
        step();
        din[0] = 8'h19;
        zr[0] = 1'b1;
        @(negedge clk);
        chk("full_pop_ir", 32'(ir[0]), 32'd0);
        chk("full_pop_count", 32'(cnt0), 32'd4);
        step();
        iv[0] = 1'b0;
        zr[0] = 1'b0;
        @(negedge clk);
        chk("after_full_pop_count", 32'(cnt0), 32'd3);
        chk("after_full_pop_z", 32'(z[0]), 32'h16);

        // Reset mid-operation with push and pop offered.
        step();
        rst = 1'b1;
        iv[0] = 1'b1;
        zr[0] = 1'b1;
        din[0] = 8'h20;
        step();
        rst = 1'b0;
        iv[0] = 1'b0;
        @(negedge clk);
        chk("midrst_count", 32'(cnt0), 32'd0);
        chk("midrst_zv", 32'(zv[0]), 32'd0);
        chk("midrst_z", 32'(z[0]), 32'd0);
        chk("midrst_ir", 32'(ir[0]), 32'd0);
        step();
        @(negedge clk);
        chk("midrst_zv2", 32'(zv[0]), 32'd0);
        chk("midrst_ir2", 32'(ir[0]), 32'd1);
        step();
        zr[0] = 1'b0;

`ifdef GF180MCU_FD_SC_MCU9T5V0_BUFQ_BYPASS_EN
        din[0] = 8'h3C;
        iv[0] = 1'b1;
        zr[0] = 1'b1;
        @(negedge clk);
        chk("byp_z", 32'(z[0]), 32'h3C);
        chk("byp_zv", 32'(zv[0]), 32'd1);
        step();
        zr[0] = 1'b0;
        @(negedge clk);
        chk("byp_count", 32'(cnt0), 32'd0);
        chk("byp_hold_z", 32'(z[0]), 32'h3C);
        step();
        iv[0] = 1'b0;
        @(negedge clk);
        chk("byp_store_count", 32'(cnt0), 32'd1);
        chk("byp_store_z", 32'(z[0]), 32'h3C);
        step();
        zr[0] = 1'b1;
        step();
        zr[0] = 1'b0;
`endif

        // Wrap-around on the DEPTH=3 instance with ZR toggling.
        sent = 0;
        for (int c = 0; c < 100 && rcv.size() < 10; c++) begin
            iv[1]  = (sent < 10);
            din[1] = 8'(sent);
            zr[1]  = (c % 2 == 0);
            @(negedge clk);
            acc = iv[1] && ir[1];
            if (zv[1] && zr[1]) rcv.push_back(z[1]);
            step();
            if (acc) sent++;
        end
        iv[1] = 1'b0;
        zr[1] = 1'b0;
        chk("wrap_received", 32'(rcv.size()), 32'd10);
        for (int j = 0; j < rcv.size(); j++) begin
            chk("wrap_order", 32'(rcv[j]), 32'(j));
        end

        // Randomized traffic on both instances, with occasional resets.
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 63) == 0);
            for (int k = 0; k < 2; k++) begin
                iv[k]  = 1'($urandom_range(0, 1));
                zr[k]  = ($urandom_range(0, 99) < ((c < 1500) ? 70 : 30));
                din[k] = 8'($urandom);
            end
            step();
        end
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            iv[k] = 1'b0;
            zr[k] = 1'b0;
        end
        step();
        step();
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/gf180mcu_fd_sc_mcu9t5v0__bufq.md
# gf180mcu_fd_sc_mcu9t5v0__bufq

Parametrised, multi-bit, elastic buffer queue for the 9-track 5 V library: the clocked successor of the single-bit combinational buffer. It accepts WIDTH-bit words on a valid/ready handshake, holds up to DEPTH of them in order, and presents them downstream on a second valid/ready handshake. It is placed wherever a plain buffer chain would otherwise carry a bus across a timing or backpressure boundary.

## Interface
- WIDTH, 1, data word width in bits (>= 1)
- DEPTH, 2, number of storage entries (>= 1; any integer, not restricted to powers of two)
- CW, $clog2(DEPTH+1), width of COUNT (derived, not overridden)
- CLK  input  1  clock; all state changes on rising edge
- RST  input  1  reset, synchronous, active-high
- I  input  WIDTH  write data
- IV  input  1  write valid
- IR  output  1  write ready
- Z  output  WIDTH  read data
- ZV  output  1  read valid
- ZR  input  1  read ready
- COUNT  output  CW  number of entries currently held
- VDD  inout  1  supply, library pinout only, no behavioural effect
- VSS  inout  1  ground, library pinout only, no behavioural effect

## Operation
- One clock; reset is synchronous and active-high.
- Storage: DEPTH x WIDTH circular array, write pointer WP, read pointer RP, occupancy COUNT.
- Push when IV && IR at rising CLK: I written to entry WP; WP advances.
- Pop when ZV && ZR at rising CLK: RP advances. Pop from storage only when COUNT != 0.
- Pointer wrap: pointer equal to DEPTH-1 advances to 0.
- COUNT: +1 on push only, -1 on pop from storage only, unchanged on simultaneous push and pop.
- IR = !RST_q && (COUNT != DEPTH). IR never depends combinationally on ZR; a full queue refuses a push even if a pop occurs in the same cycle.
- ZV = (COUNT != 0) in the base configuration.
- Z = entry RP when ZV = 1; Z = all zeros when ZV = 0 (deterministic, no stale data).
- Data order strictly FIFO; no entry is dropped or duplicated.
- IV deasserted while IR = 0 is legal; data is not captured. Upstream holds I/IV stable until accepted; downstream may drop ZR at any time.
- Reset: RST high at a rising edge clears WP, RP, COUNT to 0. RST_q is a flop set by RST, cleared the cycle after RST deasserts. Storage contents are not reset.
- Reset mid-operation: all held entries discarded; a push or pop presented in the reset cycle is ignored.

## Timing
- Reset values (cycle after RST sampled high and while it stays high): COUNT = 0, ZV = 0, Z = 0, IR = 0.
- IR rises in the first cycle after the cycle in which RST is sampled low.
- Base latency: word pushed at edge n appears on Z with ZV = 1 from edge n (visible in cycle n+1).
- Throughput: one push and one pop per cycle sustained when 0 < COUNT < DEPTH.
- DEPTH = 1: alternates push/pop; throughput 1 word per 2 cycles without bypass.
- All outputs except Z/ZV in bypass mode are flop-driven or decoded from flops only.

## Configuration
- Macro GF180MCU_FD_SC_MCU9T5V0_BUFQ_BYPASS_EN.
- Not defined: behaviour as above; minimum latency 1 cycle.
- Defined: zero-latency fall-through when empty. ZV = (COUNT != 0) || (IV && IR); Z = (COUNT != 0) ? entry RP : I. When COUNT == 0 and IV && ZR, the word passes I→Z in the same cycle, is not written, and COUNT stays 0. When COUNT == 0, IV = 1, ZR = 0, the word is written normally. During reset, ZV = 0 and Z = 0 regardless of IV.

## Test plan
- Reset: WIDTH=8, DEPTH=4, drive IV=1, I=8'hA5 with RST=1 for 3 cycles -> COUNT=0, ZV=0, Z=0, IR=0 throughout; IR=1 one cycle after RST drops.
- Fill/drain: push 8'h01..8'h04 with ZR=0 -> COUNT=4, IR=0; fifth push 8'h05 refused; then ZR=1 -> Z reads 01,02,03,04 in consecutive cycles, COUNT reaches 0, ZV=0, Z=0.
- Wrap-around: DEPTH=3, stream 10 words 8'h00..8'h09 with ZR toggling 1,0,1,0 -> output sequence exactly 00..09, COUNT never exceeds 3.
- Simultaneous push/pop: COUNT=2, IV=1, ZR=1 for 5 cycles -> COUNT stays 2, output order preserved; at COUNT=4 with ZR=1, IV=1 -> push refused, COUNT becomes 3.
- Reset mid-operation: COUNT=3, assert RST one cycle with IV=ZR=1 -> COUNT=0, ZV=0 next cycle; old entries never reappear on Z.
- Bypass (macro defined): empty, IV=1, I=8'h3C, ZR=1 -> Z=8'h3C, ZV=1 same cycle, COUNT stays 0; repeat with ZR=0 -> COUNT=1, Z=8'h3C held.
